// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline: opcodes, branch condition codes, flag bit positions.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;

  typedef enum logic [2:0] {
    CC_NE = 3'b000,
    CC_EQ = 3'b001,
    CC_GT = 3'b010,
    CC_LT = 3'b011,
    CC_GE = 3'b100,
    CC_LE = 3'b101,
    CC_OV = 3'b110,
    CC_AL = 3'b111
  } ccc_t;

  localparam int NVZ_N = 2;
  localparam int NVZ_V = 1;
  localparam int NVZ_Z = 0;

  // Which of {N,V,Z} an opcode is allowed to update; shift/logic ops only own Z.
  function automatic logic [2:0] flag_wr_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b001;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation of a condition code against {N,V,Z}.
module branch_cond
  import wisc_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] nvz,
  output logic       cond
);

  logic n, v, z;

  assign n = nvz[NVZ_N];
  assign v = nvz[NVZ_V];
  assign z = nvz[NVZ_Z];

  always_comb begin
    cond = 1'b0;
    case (ccc_t'(ccc))
      CC_NE:   cond = ~z;
      CC_EQ:   cond = z;
      CC_GT:   cond = ~z & ~n;
      CC_LT:   cond = n;
      CC_GE:   cond = z | ~n;
      CC_LE:   cond = n | z;
      CC_OV:   cond = v;
      CC_AL:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register with per-opcode write masks, and ID-stage branch resolution
// using the EX-stage flags bypassed in the same cycle.
module flag_branch_unit
  import wisc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [2:0]       ex_nvz,
  input  logic             stall,
  input  logic             flush_ex,
  input  logic             id_branch,
  input  logic             id_br_reg,
  input  logic [2:0]       id_ccc,
  input  logic [WIDTH-1:0] id_pc_plus2,
  input  logic [8:0]       id_imm9,
  input  logic [WIDTH-1:0] id_rs_data,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_target,
  output logic             flush_if_q,
  output logic [2:0]       flags_q,
  output logic [CNT_W-1:0] taken_cnt
);

  logic             wr;
  logic [2:0]       wr_mask;
  logic [2:0]       flags_d;
  logic             cond;
  logic [WIDTH-1:0] b_offset;
  logic [CNT_W-1:0] taken_cnt_d;

  assign wr      = ex_valid & ~stall & ~flush_ex;
  assign wr_mask = wr ? flag_wr_mask(ex_opcode) : 3'b000;
  assign flags_d = (flags_q & ~wr_mask) | (ex_nvz & wr_mask);

  // The branch evaluates the post-write flags so it never waits on the instruction in EX.
  branch_cond u_branch_cond (
    .ccc  (id_ccc),
    .nvz  (flags_d),
    .cond (cond)
  );

  assign br_taken  = id_branch & ~stall & cond;
  assign b_offset  = {{(WIDTH-10){id_imm9[8]}}, id_imm9, 1'b0};
  assign br_target = id_br_reg ? id_rs_data : (id_pc_plus2 + b_offset);

  always_comb begin
    taken_cnt_d = taken_cnt;
    if (br_taken && (taken_cnt != {CNT_W{1'b1}})) taken_cnt_d = taken_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q    <= 3'b000;
      flush_if_q <= 1'b0;
      taken_cnt  <= '0;
    end else begin
      flags_q    <= flags_d;
      flush_if_q <= br_taken;
      taken_cnt  <= taken_cnt_d;
    end
  end

endmodule
